// File: rtl/slave_addr_fifo_push_pkg.sv
// slave_addr_fifo_push_pkg: entry layout, burst encodings and split constants for the address-FIFO push stage
package slave_addr_fifo_push_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam int BOUNDARY  = 4096;
  localparam int OFF_BURST = 0;
  localparam int OFF_SIZE  = 2;
  localparam int OFF_LEN   = 5;
  localparam int OFF_ADDR  = 13;
  typedef enum logic {IDLE, SECOND} push_state_e;
  function automatic int off_id(input int addr_w);
    return OFF_ADDR + addr_w;
  endfunction
  function automatic int off_cont(input int id_w, input int addr_w);
    return off_id(addr_w) + id_w;
  endfunction
  function automatic int entry_w(input int id_w, input int addr_w);
    return off_cont(id_w, addr_w) + 1;
  endfunction
endpackage

// File: rtl/slave_addr_fifo_push_skid.sv
// axi_skid_buf2: 2-entry fall-through skid buffer with registered ready
module axi_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_pop_i
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q, ready_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         fire, has_q, pop_q, store;
  assign fire        = in_valid_i & ready_q;
  assign has_q       = cnt_q != 2'd0;
  assign out_valid_o = has_q | fire;
  assign out_data_o  = has_q ? mem_q[rd_q] : in_data_i;
  assign pop_q       = out_pop_i & has_q;
  // an empty buffer hands a fresh request straight through without storing it
  assign store       = fire & ~(out_pop_i & ~has_q);
  assign cnt_d       = cnt_q + 2'(store) - 2'(pop_q);
  assign in_ready_o  = ready_q;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_q ^ store;
      rd_q    <= rd_q ^ pop_q;
      ready_q <= cnt_d != 2'd2;
    end
  always_ff @(posedge wclk)
    if (store) mem_q[wr_q] <= in_data_i;
endmodule

// File: rtl/slave_addr_fifo_push.sv
// slave_addr_fifo_push: buffers AXI address requests, splits INCR bursts at 4 KB and pushes entries into the address FIFO
module slave_addr_fifo_push
  import slave_addr_fifo_push_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_W     = 9,
  parameter int FULL_MARGIN = 2
) (
  input  logic                             wclk,
  input  logic                             wrst,
  input  logic                             s_axvalid,
  output logic                             s_axready,
  input  logic [ID_W-1:0]                  s_axid,
  input  logic [ADDR_W-1:0]                s_axaddr,
  input  logic [7:0]                       s_axlen,
  input  logic [2:0]                       s_axsize,
  input  logic [1:0]                       s_axburst,
  output logic                             fifo_wen,
  output logic [entry_w(ID_W, ADDR_W)-1:0] fifo_wdata,
  input  logic                             fifo_wfull,
  input  logic [DEPTH_W:0]                 fifo_wr_water_level,
  output logic [15:0]                      req_cnt,
  output logic [15:0]                      split_cnt
);
  localparam int EW    = entry_w(ID_W, ADDR_W);
  localparam int HW    = EW - 1;
  localparam int OID   = off_id(ADDR_W);
  localparam int AW_HI = ADDR_W - 12;
  localparam logic [DEPTH_W:0] LVL_LIM = (DEPTH_W+1)'((1 << DEPTH_W) - FULL_MARGIN);
  logic [HW-1:0]     head;
  logic              head_valid, pop, acc, go, blocked, split;
  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr, addr2;
  logic [7:0]        h_len, len1, len2;
  logic [2:0]        h_size;
  logic [1:0]        h_burst;
  logic [11:0]       off;
  logic [12:0]       room;
  logic [16:0]       nbytes;
  logic [EW-1:0]     wdata_q, wdata_d;
  logic              wen_q;
  logic [15:0]       req_q, split_q;
  push_state_e       state_q;
  axi_skid_buf2 #(.W(HW)) u_skid (
    .wclk       (wclk),
    .wrst       (wrst),
    .in_valid_i (s_axvalid),
    .in_ready_o (s_axready),
    .in_data_i  ({s_axid, s_axaddr, s_axlen, s_axsize, s_axburst}),
    .out_valid_o(head_valid),
    .out_data_o (head),
    .out_pop_i  (pop)
  );
  assign h_burst = head[OFF_BURST +: 2];
  assign h_size  = head[OFF_SIZE +: 3];
  assign h_len   = head[OFF_LEN +: 8];
  assign h_addr  = head[OFF_ADDR +: ADDR_W];
  assign h_id    = head[OID +: ID_W];
  // offset of the size-aligned start within its 4 KB page
  assign off     = h_addr[11:0] & ~((12'd1 << h_size) - 12'd1);
  assign nbytes  = (17'(h_len) + 17'd1) << h_size;
  assign split   = (h_burst == BURST_INCR) & (17'(off) + nbytes > 17'(BOUNDARY));
  assign room    = 13'(BOUNDARY) - 13'(off);
  assign len1    = 8'((room >> h_size) - 13'd1);
  assign len2    = h_len - len1 - 8'd1;
  assign addr2   = {h_addr[ADDR_W-1:12] + AW_HI'(1), 12'h000};
  assign blocked = fifo_wfull | (fifo_wr_water_level >= LVL_LIM);
  assign acc     = s_axvalid & s_axready;
  assign go      = head_valid & ~blocked;
  assign pop     = go & ((state_q == SECOND) | ~split);
  assign wdata_d = (state_q == SECOND) ? {1'b0, h_id, addr2, len2, h_size, h_burst} :
                   split ? {1'b1, h_id, h_addr, len1, h_size, h_burst} :
                   {1'b0, h_id, h_addr, h_len, h_size, h_burst};
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      req_q   <= '0;
      split_q <= '0;
    end else begin
      wen_q <= go;
      if (go) wdata_q <= wdata_d;
      if (go && state_q == IDLE && split) begin
        state_q <= SECOND;
        split_q <= split_q + 16'd1;
      end else if (go && state_q == SECOND) state_q <= IDLE;
      if (acc) req_q <= req_q + 16'd1;
    end
  assign fifo_wen   = wen_q;
  assign fifo_wdata = wdata_q;
  assign req_cnt    = req_q;
  assign split_cnt  = split_q;
endmodule

// File: tb/tb_slave_addr_fifo_push.sv
// tb_slave_addr_fifo_push: directed scoreboard bench for the address-FIFO push stage
module tb_slave_addr_fifo_push;
  import slave_addr_fifo_push_pkg::*;
  localparam int EW = 50;
  logic          wclk, wrst;
  logic          s_axvalid, s_axready;
  logic [3:0]    s_axid;
  logic [31:0]   s_axaddr;
  logic [7:0]    s_axlen;
  logic [2:0]    s_axsize;
  logic [1:0]    s_axburst;
  logic          fifo_wen, fifo_wfull;
  logic [EW-1:0] fifo_wdata;
  logic [9:0]    fifo_wr_water_level;
  logic [15:0]   req_cnt, split_cnt;
  logic [EW-1:0] exp_q [$];
  int n_cmp, n_err, push_cnt, cyc, bubbles, p0, t0;
  logic last_acc;

  slave_addr_fifo_push dut (
    .wclk(wclk), .wrst(wrst),
    .s_axvalid(s_axvalid), .s_axready(s_axready),
    .s_axid(s_axid), .s_axaddr(s_axaddr), .s_axlen(s_axlen),
    .s_axsize(s_axsize), .s_axburst(s_axburst),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .fifo_wr_water_level(fifo_wr_water_level),
    .req_cnt(req_cnt), .split_cnt(split_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] sz, input logic [1:0] b);
    int unsigned step, boff, nb, n1;
    logic [31:0] a2;
    step = 1 << sz;
    boff = (a - (a % step)) % 4096;
    nb   = (int'(l) + 1) * step;
    if (b == BURST_INCR && boff + nb > 4096) begin
      n1 = (4096 - boff) / step;
      a2 = ((a / 4096) + 1) * 4096;
      exp_q.push_back({1'b1, id, a, 8'(n1 - 1), sz, b});
      exp_q.push_back({1'b0, id, a2, 8'(int'(l) - int'(n1)), sz, b});
    end else exp_q.push_back({1'b0, id, a, l, sz, b});
  endtask

  task automatic tick();
    last_acc = s_axvalid && s_axready;
    @(posedge wclk);
    #1;
    cyc++;
    if (last_acc) begin
      model(s_axid, s_axaddr, s_axlen, s_axsize, s_axburst);
      s_axvalid = 1'b0;
    end
    if (fifo_wen) begin
      push_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_push: observed %0h expected no push", fifo_wdata);
      end else chk("push_data", 64'(fifo_wdata), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] sz, input logic [1:0] b);
    s_axid = id; s_axaddr = a; s_axlen = l; s_axsize = sz; s_axburst = b;
    s_axvalid = 1'b1;
  endtask

  task automatic send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                      input logic [2:0] sz, input logic [1:0] b);
    drive(id, a, l, sz, b);
    for (int k = 0; k < 50 && s_axvalid; k++) tick();
    if (s_axvalid) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed no acceptance expected acceptance within 50 cycles");
      s_axvalid = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; push_cnt = 0; cyc = 0;
    wrst = 1'b1; s_axvalid = 1'b0; s_axid = '0; s_axaddr = '0; s_axlen = '0;
    s_axsize = '0; s_axburst = '0; fifo_wfull = 1'b0; fifo_wr_water_level = '0;
    repeat (3) tick();
    chk("rst_ready", 64'(s_axready), 0);
    chk("rst_wen", 64'(fifo_wen), 0);
    chk("rst_wdata", 64'(fifo_wdata), 0);
    chk("rst_req_cnt", 64'(req_cnt), 0);
    chk("rst_split_cnt", 64'(split_cnt), 0);
    wrst = 1'b0;
    chk("ready_before_edge", 64'(s_axready), 0);
    tick();
    chk("ready_after_release", 64'(s_axready), 1);
    // single INCR, no boundary crossing
    send(4'h3, 32'h0000_0100, 8'd3, 3'd2, BURST_INCR);
    chk("single_wen_latency", 64'(fifo_wen), 1);
    chk("single_req_cnt", 64'(req_cnt), 1);
    tick();
    chk("single_wen_pulse", 64'(fifo_wen), 0);
    // INCR crossing 4 KB
    send(4'h5, 32'h0000_0FF0, 8'd7, 3'd2, BURST_INCR);
    chk("split_e1_wen", 64'(fifo_wen), 1);
    chk("split_e1_cont", 64'(fifo_wdata[49]), 1);
    chk("split_cnt", 64'(split_cnt), 1);
    tick();
    chk("split_e2_wen", 64'(fifo_wen), 1);
    chk("split_e2_addr", 64'(fifo_wdata[44:13]), 64'h1000);
    tick();
    chk("split_done", 64'(fifo_wen), 0);
    // WRAP, FIXED and reserved bursts are never split
    send(4'h6, 32'h0000_0FF0, 8'd7, 3'd2, BURST_WRAP);
    send(4'h7, 32'h0000_0FF0, 8'd7, 3'd2, BURST_FIXED);
    send(4'h8, 32'h0000_0FF0, 8'd7, 3'd2, 2'b11);
    repeat (3) tick();
    chk("nosplit_split_cnt", 64'(split_cnt), 1);
    chk("nosplit_drained", 64'(exp_q.size()), 0);
    // water level at threshold blocks; one below releases
    fifo_wr_water_level = 10'd510;
    send(4'h1, 32'h0000_0200, 8'd0, 3'd0, BURST_INCR);
    send(4'h2, 32'h0000_0300, 8'd1, 3'd1, BURST_INCR);
    chk("blk_ready_low", 64'(s_axready), 0);
    drive(4'h3, 32'h0000_0400, 8'd2, 3'd2, BURST_INCR);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("blk_no_wen", 64'(fifo_wen), 0);
    end
    chk("blk_ready_held", 64'(s_axready), 0);
    fifo_wr_water_level = 10'd509;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("unblk_wen", 64'(fifo_wen), 1);
    end
    tick();
    chk("unblk_drained", 64'(exp_q.size()), 0);
    fifo_wr_water_level = '0;
    // fifo_wfull blocks the same way
    fifo_wfull = 1'b1;
    send(4'h9, 32'h0000_0500, 8'd0, 3'd2, BURST_INCR);
    tick();
    chk("wfull_no_wen", 64'(fifo_wen), 0);
    fifo_wfull = 1'b0;
    tick();
    chk("wfull_release_wen", 64'(fifo_wen), 1);
    tick();
    // reset while in SECOND
    send(4'hA, 32'h0000_1FF8, 8'd3, 3'd3, BURST_INCR);
    chk("rst2_e1_wen", 64'(fifo_wen), 1);
    wrst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst2_wen", 64'(fifo_wen), 0);
    chk("rst2_req_cnt", 64'(req_cnt), 0);
    chk("rst2_split_cnt", 64'(split_cnt), 0);
    chk("rst2_ready", 64'(s_axready), 0);
    repeat (2) tick();
    wrst = 1'b0;
    chk("rst2_ready_pre", 64'(s_axready), 0);
    tick();
    chk("rst2_ready_post", 64'(s_axready), 1);
    p0 = push_cnt;
    repeat (3) tick();
    chk("rst2_no_e2", 64'(push_cnt - p0), 0);
    // 100 back-to-back non-split requests
    bubbles = 0; p0 = push_cnt; t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send(4'(i), 32'h2000_0000 + 32'(i * 64), 8'(i % 4), 3'd2, BURST_INCR);
      if (!fifo_wen) bubbles++;
    end
    chk("b2b_cycles", 64'(cyc - t0), 100);
    chk("b2b_bubbles", 64'(bubbles), 0);
    repeat (3) tick();
    chk("b2b_pushes", 64'(push_cnt - p0), 100);
    chk("b2b_req_cnt", 64'(req_cnt), 100);
    chk("b2b_split_cnt", 64'(split_cnt), 0);
    chk("final_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
